// File: rtl/d_reader.sv
// -----------------------------------------------------------------------------
// d_reader
// Pulls words out of two destination FIFOs (D0, D1) with round-robin
// arbitration, registers each word two cycles after its pop strobe, checks the
// destination tag (bit 4) and keeps per-source word counters.
//
// Ports
//   clk          single clock, rising edge
//   reset_L      asynchronous active-low reset
//   enable       high permits new reads
//   D0_empty     D0 FIFO empty flag
//   D1_empty     D1 FIFO empty flag
//   D0_data_out  D0 FIFO read data, valid the cycle after D0_rd
//   D1_data_out  D1 FIFO read data, valid the cycle after D1_rd
//   D0_rd        D0 pop strobe (combinational)
//   D1_rd        D1 pop strobe (combinational)
//   data_out     last captured word
//   data_valid   data_out holds a new word this cycle
//   data_src     0 = word came from D0, 1 = from D1
//   cnt_D0       saturating count of words captured from D0
//   cnt_D1       saturating count of words captured from D1
//   dest_error   sticky tag-mismatch flag
//   state        FSM state
//
// state  | meaning
// IDLE   | waiting for enable, no reads
// ACTIVE | reading round-robin while enable is high
// DRAIN  | enable dropped, no new reads, waiting for in-flight words
// ERROR  | a mismatched word was captured; no reads until reset
// -----------------------------------------------------------------------------
module d_reader #(
   parameter int BW   = 6,
   parameter int CNTW = 5
) (
   input  logic            clk,
   input  logic            reset_L,
   input  logic            enable,
   input  logic            D0_empty,
   input  logic            D1_empty,
   input  logic [BW-1:0]   D0_data_out,
   input  logic [BW-1:0]   D1_data_out,
   output logic            D0_rd,
   output logic            D1_rd,
   output logic [BW-1:0]   data_out,
   output logic            data_valid,
   output logic            data_src,
   output logic [CNTW-1:0] cnt_D0,
   output logic [CNTW-1:0] cnt_D1,
   output logic            dest_error,
   output logic [1:0]      state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   state_t        state_q;
   logic          ptr_q;        // source whose turn it is when both have data
   logic          pend_q;       // a pop was issued last cycle
   logic          pend_src_q;   // source of that pop
   logic          rd_any;
   logic          rd_src;
   logic [BW-1:0] word_in;
   logic          mismatch;

   // Arbitration: both non-empty -> pointed source, otherwise whichever has data.
   always_comb begin
      rd_any = 1'b0;
      rd_src = 1'b0;
      if (state_q == ST_ACTIVE && enable) begin
         if (!D0_empty && !D1_empty) begin
            rd_any = 1'b1;
            rd_src = ptr_q;
         end else if (!D0_empty) begin
            rd_any = 1'b1;
            rd_src = 1'b0;
         end else if (!D1_empty) begin
            rd_any = 1'b1;
            rd_src = 1'b1;
         end
      end
   end

   assign D0_rd = rd_any & ~rd_src;
   assign D1_rd = rd_any &  rd_src;

   // FIFO data for last cycle's pop is on the bus now; bit 4 must equal the source.
   assign word_in  = pend_src_q ? D1_data_out : D0_data_out;
   assign mismatch = pend_q && (word_in[4] != pend_src_q);

   assign state = state_q;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_src_q <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         data_src   <= 1'b0;
         cnt_D0     <= '0;
         cnt_D1     <= '0;
         dest_error <= 1'b0;
      end else begin
         // Pointer always moves to the source not just read; both arbitration
         // cases reduce to that.
         if (rd_any) begin
            ptr_q <= ~rd_src;
         end

         pend_q     <= rd_any;
         pend_src_q <= rd_src;

         data_valid <= pend_q;
         if (pend_q) begin
            data_out <= word_in;
            data_src <= pend_src_q;
            if (pend_src_q) begin
               if (cnt_D1 != CNT_MAX) begin
                  cnt_D1 <= cnt_D1 + 1'b1;
               end
            end else begin
               if (cnt_D0 != CNT_MAX) begin
                  cnt_D0 <= cnt_D0 + 1'b1;
               end
            end
         end

         if (mismatch) begin
            dest_error <= 1'b1;
         end

         // A mismatch wins over any enable-driven move.
         if (mismatch) begin
            state_q <= ST_ERROR;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (enable) begin
                     state_q <= ST_ACTIVE;
                  end
               end
               ST_ACTIVE: begin
                  if (!enable) begin
                     state_q <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  if (enable) begin
                     state_q <= ST_ACTIVE;
                  end else if (!pend_q) begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_ERROR: begin
                  state_q <= ST_ERROR;
               end
               default: begin
                  state_q <= ST_ERROR;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_d_reader.sv
module tb_d_reader;

   localparam int BW   = 6;
   localparam int CNTW = 5;
   localparam int CMAX = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            reset_L;
   logic            enable;
   logic            D0_empty;
   logic            D1_empty;
   logic [BW-1:0]   D0_data_out;
   logic [BW-1:0]   D1_data_out;
   logic            D0_rd;
   logic            D1_rd;
   logic [BW-1:0]   data_out;
   logic            data_valid;
   logic            data_src;
   logic [CNTW-1:0] cnt_D0;
   logic [CNTW-1:0] cnt_D1;
   logic            dest_error;
   logic [1:0]      state;

   always #5 clk = ~clk;

   d_reader #(.BW(BW), .CNTW(CNTW)) dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .enable      (enable),
      .D0_empty    (D0_empty),
      .D1_empty    (D1_empty),
      .D0_data_out (D0_data_out),
      .D1_data_out (D1_data_out),
      .D0_rd       (D0_rd),
      .D1_rd       (D1_rd),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_src    (data_src),
      .cnt_D0      (cnt_D0),
      .cnt_D1      (cnt_D1),
      .dest_error  (dest_error),
      .state       (state)
   );

   typedef struct {
      logic [BW-1:0] data;
      logic          src;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];
   logic [BW-1:0] dlog[$];
   int            nvec = 0;
   int            nerr = 0;
   int            cyc  = 0;

   // reference model state
   int   mstate = 0;   // 0 idle, 1 active, 2 drain, 3 error
   logic mturn  = 1'b0;
   logic p0 = 1'b0, p1 = 1'b0;
   int   mc0 = 0, mc1 = 0;
   logic merr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      nvec++;
      nerr++;
      $display("FAIL %s cyc=%0d: got event, expected none", name, cyc);
   endtask

   function automatic logic [BW-1:0] word(input logic src, input logic bad);
      logic [BW-1:0] w;
      w    = BW'($urandom);
      w[4] = src ^ bad;
      return w;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a word.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_L) begin
         mc0  = 0;
         mc1  = 0;
         merr = 1'b0;
      end else begin
         if (data_valid) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_valid");
            end else begin
               e = sb.pop_front();
               chk("data_out", data_out, e.data);
               chk("data_src", data_src, e.src);
               chk("latency", cyc, e.due);
               dlog.push_back(data_out);
               if (e.src) begin
                  if (mc1 < CMAX) mc1++;
               end else begin
                  if (mc0 < CMAX) mc0++;
               end
               if (e.data[4] != e.src) merr = 1'b1;
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("missing_valid", 0, 1);
            sb.delete(0);
         end
         chk("cnt_D0", cnt_D0, mc0);
         chk("cnt_D1", cnt_D1, mc1);
         chk("dest_error", dest_error, merr);
      end
   end

   // Behavioural view: reads happen only while actively enabled; with data in
   // both FIFOs the sources alternate, otherwise the one with data is taken
   // and the turn passes to the other. Leaving drain waits for every
   // outstanding word; a delivered mis-tagged word locks the block in error.
   task automatic step_model();
      int   ncand;
      logic pick;
      int   exp_rd;
      bit   bad_next;
      bit   busy;
      exp_t e;
      chk("state", state, mstate);
      ncand  = int'(!D0_empty) + int'(!D1_empty);
      exp_rd = 0;
      pick   = 1'b0;
      if (mstate == 1 && enable && ncand > 0) begin
         pick   = (ncand == 2) ? mturn : D0_empty;
         exp_rd = pick ? 2 : 1;
         mturn  = ~pick;
         e.data = pick ? q1[0] : q0[0];
         e.src  = pick;
         e.due  = cyc + 2;
         sb.push_back(e);
      end
      chk("rd", {D1_rd, D0_rd}, exp_rd);
      p0 = D0_rd;
      p1 = D1_rd;
      bad_next = 0;
      busy     = 0;
      foreach (sb[i]) begin
         if (sb[i].due == cyc + 1 && sb[i].data[4] != sb[i].src) bad_next = 1;
         if (sb[i].due > cyc) busy = 1;
      end
      if (mstate == 3 || bad_next) mstate = 3;
      else if (mstate == 0 && enable) mstate = 1;
      else if (mstate == 1 && !enable) mstate = 2;
      else if (mstate == 2 && enable) mstate = 1;
      else if (mstate == 2 && !busy) mstate = 0;
   endtask

   // One clock: present FIFO flags, check at negedge, apply pops after posedge.
   task automatic cycle();
      D0_empty = (q0.size() == 0);
      D1_empty = (q1.size() == 0);
      @(negedge clk);
      step_model();
      @(posedge clk);
      #1;
      if (p0) begin
         if (q0.size() > 0) D0_data_out = q0.pop_front();
         else fail_now("rd_on_empty_D0");
      end
      if (p1) begin
         if (q1.size() > 0) D1_data_out = q1.pop_front();
         else fail_now("rd_on_empty_D1");
      end
      p0 = 1'b0;
      p1 = 1'b0;
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic do_reset();
      #2;
      reset_L = 1'b0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_valid", data_valid, 0);
      chk("rst_data", data_out, 0);
      chk("rst_src", data_src, 0);
      chk("rst_cnt_D0", cnt_D0, 0);
      chk("rst_cnt_D1", cnt_D1, 0);
      chk("rst_dest_error", dest_error, 0);
      chk("rst_rd", {D1_rd, D0_rd}, 0);
      sb.delete();
      q0.delete();
      q1.delete();
      dlog.delete();
      mstate = 0;
      mturn  = 1'b0;
      p0     = 1'b0;
      p1     = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      reset_L = 1'b1;
   endtask

   initial begin
      logic [BW-1:0] exp_a[4];
      reset_L     = 1'b0;
      enable      = 1'b0;
      D0_empty    = 1'b1;
      D1_empty    = 1'b1;
      D0_data_out = '0;
      D1_data_out = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_L = 1'b1;
      repeat (3) cycle();

      // single source
      do_reset();
      q0.push_back(6'h05);
      q0.push_back(6'h06);
      q0.push_back(6'h07);
      enable = 1'b1;
      repeat (8) cycle();
      chk("t1_cnt_D0", cnt_D0, 3);
      chk("t1_cnt_D1", cnt_D1, 0);
      chk("t1_words", dlog.size(), 3);
      exp_a[0] = 6'h05; exp_a[1] = 6'h06; exp_a[2] = 6'h07;
      for (int i = 0; i < 3 && i < dlog.size(); i++) chk("t1_order", dlog[i], exp_a[i]);
      enable = 1'b0;
      repeat (3) cycle();
      chk("t1_idle", state, 0);

      // round robin
      do_reset();
      q0.push_back(6'h01);
      q0.push_back(6'h02);
      q1.push_back(6'h11);
      q1.push_back(6'h12);
      enable = 1'b1;
      repeat (8) cycle();
      exp_a[0] = 6'h01; exp_a[1] = 6'h11; exp_a[2] = 6'h02; exp_a[3] = 6'h12;
      chk("t2_words", dlog.size(), 4);
      for (int i = 0; i < 4 && i < dlog.size(); i++) chk("t2_order", dlog[i], exp_a[i]);

      // mismatch
      do_reset();
      q1.push_back(6'h03);
      enable = 1'b1;
      repeat (4) cycle();
      q0.push_back(6'h01);
      q1.push_back(6'h15);
      repeat (6) cycle();
      chk("t3_state", state, 3);
      chk("t3_dest_error", dest_error, 1);
      chk("t3_words", dlog.size(), 1);
      if (dlog.size() > 0) chk("t3_data", dlog[0], 6'h03);
      chk("t3_no_rd_D0", q0.size(), 1);
      chk("t3_no_rd_D1", q1.size(), 1);

      // counter saturation
      do_reset();
      repeat (40) q0.push_back(word(1'b0, 1'b0));
      enable = 1'b1;
      repeat (46) cycle();
      chk("t4_cnt_D0", cnt_D0, CMAX);
      chk("t4_words", dlog.size(), 40);

      // enable drop right after a read
      do_reset();
      repeat (4) q0.push_back(word(1'b0, 1'b0));
      enable = 1'b1;
      repeat (2) cycle();
      enable = 1'b0;
      chk("t5_active", state, 1);
      cycle();
      chk("t5_drain", state, 2);
      cycle();
      chk("t5_idle", state, 0);
      repeat (2) cycle();
      chk("t5_words", dlog.size(), 1);
      chk("t5_left", q0.size(), 3);

      // randomized traffic, later trials with occasional mis-tagged words
      for (int t = 0; t < 6; t++) begin
         do_reset();
         for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 8)
               q0.push_back(word(1'b0, (t >= 3) && ($urandom_range(0, 40) == 0)));
            if ($urandom_range(0, 3) == 0 && q1.size() < 8)
               q1.push_back(word(1'b1, (t >= 3) && ($urandom_range(0, 40) == 0)));
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/d_reader.md
D_READER -- requirements
Module: d_reader

Interface
REQ-001 SHALL have parameter BW, default 6, width of a data word.
REQ-002 SHALL have parameter CNTW, default 5, width of each per-destination word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  high permits new reads.
REQ-006 SHALL have ports D0_empty, D1_empty  input  1 each  destination FIFO empty flags.
REQ-007 SHALL have ports D0_data_out, D1_data_out  input  BW each  destination FIFO read data, valid the cycle after the matching rd.
REQ-008 SHALL have ports D0_rd, D1_rd  output  1 each  FIFO pop strobes.
REQ-009 SHALL have port data_out  output  BW  registered captured word.
REQ-010 SHALL have port data_valid  output  1  data_out holds a new word this cycle.
REQ-011 SHALL have port data_src  output  1  0 = word came from D0, 1 = from D1.
REQ-012 SHALL have ports cnt_D0, cnt_D1  output  CNTW each  words received per destination.
REQ-013 SHALL have port dest_error  output  1  sticky destination-mismatch flag.
REQ-014 SHALL have port state  output  2  FSM state: IDLE=0, ACTIVE=1, DRAIN=2, ERROR=3.

Function
REQ-015 SHALL drive D0_rd/D1_rd combinationally: at most one high per cycle, only in ACTIVE with enable=1, never to an empty FIFO.
REQ-016 SHALL arbitrate round-robin with a 1-bit pointer: both non-empty -> read pointed FIFO, then toggle pointer; only one non-empty -> read it and set pointer to the other.
REQ-017 SHALL keep the pointer unchanged in cycles with no read.
REQ-018 SHALL use a two-stage pipeline: rd in cycle N -> pending flag and source registered at edge ending N -> FIFO word captured at edge ending N+1 -> data_out/data_valid/data_src visible in cycle N+2.
REQ-019 SHALL sustain one word per cycle when FIFOs stay non-empty.
REQ-020 SHALL hold data_out at its last value and data_valid=0 in cycles with no capture.
REQ-021 SHALL treat data bit 4 as the destination tag: expected 0 for D0, 1 for D1.
REQ-022 SHALL increment cnt_D0/cnt_D1 on each captured word from that source, mismatched words included, saturating at 2^CNTW-1.
REQ-023 SHALL on capturing a mismatched word: output it with data_valid=1, set dest_error=1 in the same cycle, and enter ERROR.
REQ-024 SHALL transition IDLE->ACTIVE when enable=1, ACTIVE->DRAIN when enable=0, DRAIN->IDLE once no read is pending in either pipeline stage, and DRAIN->ACTIVE if enable returns to 1 first.
REQ-025 SHALL, in DRAIN, issue no new rd but deliver all in-flight words.
REQ-026 SHALL, in ERROR, issue no rd, still deliver in-flight words, and leave ERROR only through reset.
REQ-027 SHALL give a mismatch priority over any enable-driven transition in the same cycle.

Reset
REQ-028 SHALL, while reset_L=0, force state=IDLE, pointer=D0, pending flags=0, data_out=0, data_valid=0, data_src=0, cnt_D0=cnt_D1=0, dest_error=0, and D0_rd=D1_rd=0, independent of clk.
REQ-029 SHALL discard in-flight reads when reset asserts mid-operation, with no data_valid produced for them after release.

Verification
REQ-030 Reset: assert reset_L=0 mid-stream -> all outputs 0 and state=0 immediately, without a clock edge.
REQ-031 Single source: enable=1, D0 holds 0x05,0x06,0x07, D1 empty -> D0_rd high 3 consecutive cycles; data_out 0x05,0x06,0x07 with data_valid=1 and data_src=0 two cycles later; cnt_D0=3, cnt_D1=0.
REQ-032 Round-robin: both FIFOs hold 2 words (D0 0x01,0x02; D1 0x11,0x12) -> read order D0,D1,D0,D1; data_out 0x01,0x11,0x02,0x12.
REQ-033 Mismatch: D1 holds 0x03 (bit4=0) -> data_out=0x03, dest_error=1, state=3; no rd afterward despite further non-empty FIFOs.
REQ-034 Saturation: 40 valid D0 words -> cnt_D0 stops at 31.
REQ-035 Enable drop: drop enable in the same cycle as a D0_rd -> no further rd; pending words delivered; state 1->2->0.
